// File: rtl/bfxp_pkg.sv
// bfxp_pkg: shared types and mask helpers for the bit-field extract/place pipe
package bfxp_pkg;

  typedef enum logic [1:0] {
    BFXP_ZERO  = 2'd0,
    BFXP_SIGN  = 2'd1,
    BFXP_MERGE = 2'd2
  } mode_t;

  function automatic int lg(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic logic [63:0] low_ones(input logic [7:0] n);
    return n >= 8'd64 ? {64{1'b1}} : (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic [63:0] shl_ones(input logic [7:0] n);
    return n >= 8'd64 ? 64'd0 : {64{1'b1}} << n;
  endfunction

endpackage

// File: rtl/bfxp_pipe_rorw.sv
// rorw: combinational rotate-right of an XLEN-bit word
module rorw
  import bfxp_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SW = lg(XLEN)
) (
  input  logic [XLEN-1:0] data,
  input  logic [SW-1:0]   amt,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] w;

  assign w      = {data, data} >> amt;
  assign result = w[XLEN-1:0];

endmodule

// File: rtl/bfxp_pipe.sv
// bfxp_pipe: two-stage bit-field extract-and-place with zero/sign/merge fill
module bfxp_pipe
  import bfxp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAGW = 4,
  localparam int SW = lg(XLEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_mode,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [SW-1:0]   in_start,
  input  logic [SW:0]     in_len,
  input  logic [SW-1:0]   in_dest,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rd,
  output logic            out_err,
  output logic [TAGW-1:0] out_tag
);

  localparam int EW = SW + 2;

  logic            s1_v, s2_v, s1_load, s2_load;
  logic [EW-1:0]   end_pos, src_end;
  logic [XLEN-1:0] rot, lmask, rmask, field, rd;
  logic            sign, err;
  mode_t           mode;
  logic [XLEN-1:0] s1_rot, s1_mask, s1_upper, s1_rs2;
  logic            s1_sign, s1_err;
  mode_t           s1_mode;
  logic [TAGW-1:0] s1_tag;

  assign s2_load   = !s2_v || out_ready;
  assign s1_load   = !s1_v || s2_load;
  assign in_ready  = !reset && s1_load;
  assign out_valid = s2_v;

  rorw #(.XLEN(XLEN)) u_rorw (
    .data  (in_rs1),
    .amt   (SW'(in_start - in_dest)),
    .result(rot)
  );

  always_comb begin
    end_pos = EW'(in_dest) + EW'(in_len);
    src_end = EW'(in_start) + EW'(in_len);
    err     = src_end > EW'(XLEN) || end_pos > EW'(XLEN);
    lmask   = XLEN'(low_ones(8'(end_pos)));
    rmask   = XLEN'(shl_ones(8'(in_dest)));
    sign    = in_len != '0 && rot[SW'(end_pos - EW'(1))];
    mode    = in_mode == 2'd3 ? BFXP_ZERO : mode_t'(in_mode);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_v     <= 1'b0;
      s1_rot   <= '0;
      s1_mask  <= '0;
      s1_upper <= '0;
      s1_rs2   <= '0;
      s1_sign  <= 1'b0;
      s1_err   <= 1'b0;
      s1_mode  <= BFXP_ZERO;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_rot   <= rot;
        s1_mask  <= lmask & rmask;
        s1_upper <= ~lmask;
        s1_rs2   <= in_rs2;
        s1_sign  <= sign;
        s1_err   <= err;
        s1_mode  <= mode;
        s1_tag   <= in_tag;
      end
    end
  end

  // a flagged range error leaves the background untouched instead of placing a field
  always_comb begin
    field = s1_rot & s1_mask;
    rd = s1_err ? (s1_mode == BFXP_MERGE ? s1_rs2 : '0) :
         s1_mode == BFXP_MERGE ? field | (s1_rs2 & ~s1_mask) :
         s1_mode == BFXP_SIGN && s1_sign ? field | s1_upper : field;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_v    <= 1'b0;
      out_rd  <= '0;
      out_err <= 1'b0;
      out_tag <= '0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_rd  <= rd;
        out_err <= s1_err;
        out_tag <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_bfxp_pipe.sv
// tb_bfxp_pipe: scoreboard bench for bfxp_pipe with directed and random stimulus
module tb_bfxp_pipe;

  logic        clock = 0, reset = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1, out_err;
  logic [1:0]  in_mode = 0;
  logic [31:0] in_rs1 = 0, in_rs2 = 0, out_rd;
  logic [4:0]  in_start = 0, in_dest = 0;
  logic [5:0]  in_len = 0;
  logic [3:0]  in_tag = 0, out_tag;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0, accepted = 0;
  bit rnd_ready = 0;

  bfxp_pipe #(.XLEN(32), .TAGW(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_start(in_start),
    .in_len(in_len), .in_dest(in_dest), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_rd(out_rd), .out_err(out_err), .out_tag(out_tag)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int mode, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input int s, input int l, input int d, input logic [3:0] tag);
    exp_t e;
    longint unsigned m, f, r;
    if (mode == 3) mode = 0;
    e.tag = tag;
    e.err = (s + l > 32) || (d + l > 32);
    if (e.err) e.rd = mode == 2 ? rs2 : 32'd0;
    else begin
      m = (64'd1 << l) - 64'd1;
      f = ({32'd0, rs1} >> s) & m;
      r = f << d;
      if (mode == 1 && l > 0 && ((f >> (l - 1)) & 64'd1) == 64'd1) r |= ~((64'd1 << (d + l)) - 64'd1);
      if (mode == 2) r |= {32'd0, rs2} & ~(m << d);
      e.rd = r[31:0];
    end
    return e;
  endfunction

  task automatic send(input int mode, input logic [31:0] rs1, input logic [31:0] rs2,
                      input int s, input int l, input int d, input logic [3:0] tag, input bit lat);
    exp_t e;
    int n;
    in_valid = 1; in_mode = 2'(mode); in_rs1 = rs1; in_rs2 = rs2;
    in_start = 5'(s); in_len = 6'(l); in_dest = 5'(d); in_tag = tag;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e = model(mode, rs1, rs2, s, l, d, tag);
      e.acc = cyc;
      e.lat = lat;
      q.push_back(e);
      accepted++;
    end
    @(posedge clock);
    #1 in_valid = 0;
  endtask

  initial forever begin
    @(posedge clock);
    #1 if (rnd_ready) out_ready = $urandom_range(0, 3) != 0;
  end

  logic        stalled = 0;
  logic [36:0] held;
  always @(negedge clock) begin
    exp_t e;
    if (reset) stalled = 0;
    else begin
      if (stalled) chk("stall_stable", {out_valid, out_rd, out_tag}, held);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", {out_tag, out_rd}, 0);
        else begin
          e = q.pop_front();
          chk("out_rd", out_rd, e.rd);
          chk("out_err", out_err, e.err);
          chk("out_tag", out_tag, e.tag);
          if (e.lat) chk("latency", cyc - e.acc, 2);
        end
      end
      stalled = out_valid && !out_ready;
      held = {out_valid, out_rd, out_tag};
    end
  end

  initial begin
    int n;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clock); #1;

    send(0, 32'hDEADBEEF, 0, 8, 8, 4, 4'h1, 1);
    send(1, 32'h00008000, 0, 12, 4, 0, 4'h2, 1);
    send(1, 32'h00007000, 0, 12, 4, 0, 4'h3, 1);
    send(2, 32'h00000000, 32'hFFFFFFFF, 0, 8, 8, 4'h4, 1);
    send(0, 32'hFFFFFFFF, 0, 28, 8, 0, 4'h5, 1);
    send(2, 32'hFFFFFFFF, 32'h12345678, 0, 4, 30, 4'h6, 1);
    send(0, 32'hA5A5A5A5, 0, 0, 32, 0, 4'h7, 1);
    send(2, 32'hA5A5A5A5, 32'h5A5A5A5A, 3, 0, 9, 4'h8, 1);
    send(1, 32'hFFFFFFFF, 0, 5, 0, 7, 4'h9, 1);
    send(3, 32'h0000F000, 0, 12, 4, 16, 4'hA, 1);
    repeat (4) begin @(posedge clock); #1; end
    chk("directed_drained", q.size(), 0);

    out_ready = 0;
    accepted = 0;
    fork
      for (int i = 1; i <= 4; i++) send(1, 32'h80000000 >> i, 32'h0, 31 - i, 4, i, 4'(i), 0);
      begin
        repeat (4) @(negedge clock);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_accepted", accepted, 2);
        @(posedge clock); #1 out_ready = 1;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
          chk("bp_no_gap", out_valid, 1);
          @(negedge clock);
        end
      end
    join
    repeat (3) begin @(posedge clock); #1; end

    send(0, 32'h11111111, 0, 0, 8, 0, 4'hB, 0);
    send(0, 32'h22222222, 0, 0, 8, 0, 4'hC, 0);
    #2 reset = 1;
    #1 chk("reset_async_valid", out_valid, 0);
    q.delete();
    @(posedge clock); #1 reset = 0;
    repeat (3) begin
      @(negedge clock);
      chk("no_stale_after_reset", out_valid, 0);
    end
    @(posedge clock); #1;
    send(2, 32'h000000FF, 32'hF0F0F0F0, 0, 8, 24, 4'hD, 1);
    repeat (3) begin @(posedge clock); #1; end
    chk("post_reset_drained", q.size(), 0);

    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 3), $urandom, $urandom, $urandom_range(0, 31),
           $urandom_range(0, 4) == 0 ? 32 : $urandom_range(0, 32), $urandom_range(0, 31),
           4'($urandom), 0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
    end
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    chk("final_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bfxp_pipe.md
Name: bfxp_pipe

Overview:
Parametrised, pipelined bit-field extract-and-place unit for the bitmanip datapath. It takes field `[start+len-1:start]` of rs1 and places it at `[dest+len-1:dest]` of the result. It supports three modes: zero-fill, sign-fill and merge-into-rs2. Valid/ready handshakes on both sides sustain one operation per cycle under backpressure; the block sits between operand read and writeback.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAGW, 4, width of the opaque tag carried alongside each operation.

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation offered
in_ready  output  1  operation accepted when in_valid && in_ready
in_mode  input  2  0=zero-fill, 1=sign-fill, 2=merge, 3=reserved (treated as 0)
in_rs1  input  XLEN  source word
in_rs2  input  XLEN  background word for merge mode
in_start  input  log2(XLEN)  field LSB in rs1
in_len  input  log2(XLEN)+1  field length, 0..XLEN
in_dest  input  log2(XLEN)  field LSB in result
in_tag  input  TAGW  passed through unchanged
out_valid  output  1  result available
out_ready  input  1  result consumed when out_valid && out_ready
out_rd  output  XLEN  result
out_err  output  1  range violation flagged for this result
out_tag  output  TAGW  tag of this result

Behaviour:
- Reset (async assert, sync release): stage valids=0, out_valid=0, out_rd=0, out_err=0, out_tag=0. in_ready=1 while reset is deasserted and the pipe is empty.
- Reset mid-operation drops all in-flight operations; nothing is emitted for them.
- Pipeline has two register stages (S1, S2). S2 drives the outputs.
- Latency is exactly 2 cycles from acceptance to out_valid when out_ready=1 is held. Throughput is 1/cycle.
- Stall rules:
  - S2 loads when it is empty or out_ready=1.
  - S1 loads when it is empty or S2 loads.
  - in_ready = S1 empty || S2 loads.
  - Payload of a stalled stage is held stable; out_* are stable while out_valid && !out_ready.
- S1 computes:
  - rot = rs1 rotated right by (start-dest) mod XLEN.
  - rmask = ones << dest.
  - lmask = ones below bit dest+len.
  - err = (start+len > XLEN) || (dest+len > XLEN).
  - Sums are computed in log2(XLEN)+2 bits so they never wrap.
  - S1 registers rot, mask=lmask&rmask, sign bit rot[dest+len-1] (0 if len=0), the upper-fill mask (ones at bit ≥ dest+len), mode, rs2, tag and err.
- S2 computes:
  - mode 0: rd = rot & mask.
  - mode 1: rd = (rot & mask) | (sign ? upper-fill : 0). Bits below dest are 0.
  - mode 2: rd = (rot & mask) | (rs2 & ~mask).
  - If err: rd = 0 in modes 0/1, rd = rs2 in mode 2; out_err=1.
- len=0 (no error): mask=0, so rd=0 in modes 0/1 and rd=rs2 in mode 2. Sign is 0.
- len=XLEN with start=dest=0 is legal: full-word copy, rd=rs1.
- Simultaneous accept and emit in the same cycle is allowed; ordering is strictly FIFO.
- No operation is lost or duplicated under any in_valid/out_ready pattern.

Decomposition:
- Shared package bfxp_pkg holds:
  - mode enum: BFXP_ZERO=0, BFXP_SIGN=1, BFXP_MERGE=2.
  - function for log2(XLEN).
  - mask-construction functions (low-ones of n bits, ones-shifted-left).
- One sub-module, rorw: combinational parametrised rotate-right, XLEN-bit data with log2(XLEN)-bit shift. It is instantiated in S1.

Test Plan:
1. XLEN=32, mode 0, rs1=0xDEADBEEF, start=8, len=8, dest=4, out_ready=1 -> out_rd=0x00000BE0, out_err=0, out_valid exactly 2 cycles after accept.
2. Mode 1, rs1=0x00008000, start=12, len=4, dest=0 -> out_rd=0xFFFFFFF8. Same with rs1=0x00007000 -> 0x00000007.
3. Mode 2, rs1=0x00000000, rs2=0xFFFFFFFF, start=0, len=8, dest=8 -> out_rd=0xFFFF00FF.
4. Range errors:
   - Mode 0, start=28, len=8 -> out_rd=0, out_err=1.
   - Mode 2, dest=30, len=4, rs2=0x12345678 -> out_rd=0x12345678, out_err=1.
   - len=32, start=0, dest=0, rs1=0xA5A5A5A5 -> out_rd=0xA5A5A5A5, out_err=0.
5. Backpressure:
   - Setup: 4 back-to-back ops with tags 1..4; out_ready=0 for cycles 2..5, then 1.
   - in_ready drops after 2 ops are held.
   - out_* stay stable while stalled.
   - Tags emerge 1,2,3,4 with no gaps once draining; correct results throughout.
6. Assert reset for 1 cycle while 2 ops are in flight -> out_valid=0 immediately (asynchronously). No stale results after release. The next op completes with 2-cycle latency.
